// File: rtl/pift_pkg.sv
// Shared types for the PIFT taint_sum consumer: event record, logger FSM states and a
// popcount helper used by the live-taint counter.
package pift_pkg;

  localparam int NUM_SRC = 16;
  localparam int TS_W    = 32;
  localparam int CNT_W   = $clog2(NUM_SRC + 1);

  typedef struct packed {
    logic               last;
    logic [NUM_SRC-1:0] vec;
    logic [TS_W-1:0]    time_stamp;
  } taint_evt_t;

  localparam int EVT_W = $bits(taint_evt_t);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } tel_state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SRC-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/taint_evt_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken when the
// head is popped in the same cycle.
module taint_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     pos_clk,
  input  logic                     pos_arst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW + 1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array is deliberately not reset; only pointers and count carry
  // state that matters, and the head output is forced to zero while empty.
  always_ff @(posedge pos_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge pos_arst or posedge pos_clk) begin
    if (pos_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/taint_event_logger.sv
// Samples taint_sum flags every cycle, queues a timestamped snapshot on every change and
// an end-of-run marker when logging stops; observation only, never drives the SoC.
module taint_event_logger
  import pift_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic               pos_clk,
  input  logic               pos_arst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] src_taint,
  input  logic               clr_overflow,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [NUM_SRC-1:0] ev_vec,
  output logic [TS_W-1:0]    ev_time,
  output logic               ev_last,
  output logic [CNT_W-1:0]   taint_cnt,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  tel_state_e         state;
  logic [TS_W-1:0]    ts;
  logic [NUM_SRC-1:0] prev_vec;
  logic [NUM_SRC-1:0] samp;
  logic               changed;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FCNT_W-1:0]  fifo_count;
  taint_evt_t         push_evt;
  taint_evt_t         head_evt;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no latch can be inferred on any path.
  always_comb begin
    samp = '0;
    for (int i = 0; i < NUM_SRC; i++) samp[i] = (src_taint[i] === 1'b1);
  end

  assign pop      = ev_valid && ev_ready;
  assign push_ok  = (fifo_count < FCNT_W'(FIFO_DEPTH)) || (fifo_full && pop);
  assign changed  = (state == RUN) && (samp != prev_vec);
  assign push_req = changed || (state == FLUSH);
  assign drop     = changed && !push_ok;

  always_comb begin
    push_evt            = '0;
    push_evt.time_stamp = ts;
    if (state == FLUSH) begin
      push_evt.last = 1'b1;
      push_evt.vec  = prev_vec;
    end else begin
      push_evt.last = 1'b0;
      push_evt.vec  = samp;
    end
  end

  // ts only advances in RUN, so the end-of-run marker carries the timestamp that
  // followed the last RUN cycle even if the flush stalls.
  always_ff @(posedge pos_arst or posedge pos_clk) begin
    if (pos_arst) begin
      state    <= IDLE;
      ts       <= '0;
      prev_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state    <= RUN;
            ts       <= '0;
            prev_vec <= '0;
          end
        end
        RUN: begin
          ts       <= ts + 1'b1;
          prev_vec <= samp;
          if (!en) state <= FLUSH;
        end
        FLUSH: begin
          if (push_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pos_arst or posedge pos_clk) begin
    if (pos_arst) begin
      taint_cnt <= '0;
    end else begin
      taint_cnt <= popcount(samp);
    end
  end

  // A drop in the same cycle as a clear still registers, so it is never lost.
  always_ff @(posedge pos_arst or posedge pos_clk) begin
    if (pos_arst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)         drop_cnt <= DROP_W'(1);
      else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  taint_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .pos_clk   (pos_clk),
    .pos_arst  (pos_arst),
    .push      (push_req),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_vec   = head_evt.vec;
  assign ev_time  = head_evt.time_stamp;
  assign ev_last  = head_evt.last;

endmodule

// File: tb/tb_taint_event_logger.sv
// Directed bench for taint_event_logger: a scoreboard queue of expected events is filled
// by the stimulus and drained by a monitor at every stream handshake.
module tb_taint_event_logger;
  import pift_pkg::*;

  logic               pos_clk;
  logic               pos_arst;
  logic               en;
  logic [NUM_SRC-1:0] src_taint;
  logic               clr_overflow;
  logic               ev_valid;
  logic               ev_ready;
  logic [NUM_SRC-1:0] ev_vec;
  logic [TS_W-1:0]    ev_time;
  logic               ev_last;
  logic [CNT_W-1:0]   taint_cnt;
  logic               overflow;
  logic [15:0]        drop_cnt;

  int compared   = 0;
  int mismatched = 0;

  taint_evt_t exp_q[$];

  taint_event_logger #(
    .FIFO_DEPTH (8),
    .DROP_W     (16)
  ) dut (
    .pos_clk      (pos_clk),
    .pos_arst     (pos_arst),
    .en           (en),
    .src_taint    (src_taint),
    .clr_overflow (clr_overflow),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_vec       (ev_vec),
    .ev_time      (ev_time),
    .ev_last      (ev_last),
    .taint_cnt    (taint_cnt),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  initial begin
    pos_clk = 1'b0;
    forever #5 pos_clk = ~pos_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pos_clk);
    #1;
  endtask

  task automatic expect_evt(input logic last, input logic [NUM_SRC-1:0] vec,
                            input logic [TS_W-1:0] t);
    taint_evt_t e;
    e.last       = last;
    e.vec        = vec;
    e.time_stamp = t;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    pos_arst = 1'b1;
    #2;
    exp_q.delete();
    pos_arst = 1'b0;
    #1;
  endtask

  // Monitor: every accepted event must match the oldest expected entry.
  initial begin
    taint_evt_t e;
    forever begin
      @(negedge pos_clk);
      if (!pos_arst && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got vec=%0h time=%0h last=%0b expected none",
                   ev_vec, ev_time, ev_last);
        end else begin
          e = exp_q.pop_front();
          check("ev_vec",  64'(ev_vec),  64'(e.vec));
          check("ev_time", 64'(ev_time), 64'(e.time_stamp));
          check("ev_last", 64'(ev_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    pos_arst     = 1'b1;
    en           = 1'b0;
    src_taint    = '0;
    clr_overflow = 1'b0;
    ev_ready     = 1'b0;
    #1;

    // Test 1: reset state, then a single change observed at ts 3
    do_reset();
    check("rst_ev_valid",  64'(ev_valid),  64'd0);
    check("rst_ev_vec",    64'(ev_vec),    64'd0);
    check("rst_ev_time",   64'(ev_time),   64'd0);
    check("rst_ev_last",   64'(ev_last),   64'd0);
    check("rst_taint_cnt", 64'(taint_cnt), 64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    en = 1'b1; ev_ready = 1'b1;
    step(1);
    step(3);
    src_taint = 16'h0001;
    expect_evt(1'b0, 16'h0001, 32'd3);
    step(1);
    check("t1_taint_cnt", 64'(taint_cnt), 64'd1);
    check("t1_ev_valid",  64'(ev_valid),  64'd1);
    step(2);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Test 2: taint already present on RUN entry is logged at time 0, once
    do_reset();
    src_taint = 16'h00F0; en = 1'b1; ev_ready = 1'b1;
    step(1);
    expect_evt(1'b0, 16'h00F0, 32'd0);
    step(6);
    check("t2_taint_cnt", 64'(taint_cnt), 64'd4);
    check("t2_drained",   64'(exp_q.size()), 64'd0);
    check("t2_ev_valid",  64'(ev_valid), 64'd0);

    // Test 3: overflow with the sink stalled, clear/drop collision, then ordered drain
    do_reset();
    src_taint = '0; en = 1'b1; ev_ready = 1'b0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      src_taint = NUM_SRC'(i + 1);
      if (i < 8) expect_evt(1'b0, NUM_SRC'(i + 1), TS_W'(i));
      step(1);
    end
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    src_taint = 16'd11; clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("t3_clr_drop_overflow", 64'(overflow), 64'd1);
    check("t3_clr_drop_cnt",      64'(drop_cnt), 64'd1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("t3_clr_overflow", 64'(overflow), 64'd0);
    check("t3_clr_cnt",      64'(drop_cnt), 64'd0);
    ev_ready = 1'b1;
    step(10);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Test 4: full FIFO, pop and change in the same cycle -> push accepted
    do_reset();
    src_taint = '0; en = 1'b1; ev_ready = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      src_taint = NUM_SRC'(i + 1);
      expect_evt(1'b0, NUM_SRC'(i + 1), TS_W'(i));
      step(1);
    end
    ev_ready = 1'b1; src_taint = 16'h0100;
    expect_evt(1'b0, 16'h0100, 32'd8);
    step(1);
    ev_ready = 1'b0;
    check("t4_no_drop",     64'(drop_cnt), 64'd0);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    src_taint = 16'h0200;
    step(1);
    check("t4_still_full_drop", 64'(drop_cnt), 64'd1);
    ev_ready = 1'b1;
    step(10);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Test 5: stop logging with FIFO full -> marker waits in FLUSH without dropping
    do_reset();
    src_taint = '0; en = 1'b1; ev_ready = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      src_taint = NUM_SRC'(i + 1);
      expect_evt(1'b0, NUM_SRC'(i + 1), TS_W'(i));
      step(1);
    end
    en = 1'b0;
    expect_evt(1'b1, 16'd8, 32'd9);
    step(4);
    check("t5_flush_no_drop", 64'(drop_cnt), 64'd0);
    check("t5_flush_valid",   64'(ev_valid), 64'd1);
    ev_ready = 1'b1;
    step(12);
    check("t5_drained",  64'(exp_q.size()), 64'd0);
    check("t5_ev_valid", 64'(ev_valid), 64'd0);

    // Test 6: asynchronous reset in the middle of a stalled burst
    do_reset();
    src_taint = '0; en = 1'b1; ev_ready = 1'b0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      src_taint = NUM_SRC'(16'h0100 + i);
      step(1);
    end
    check("t6_pre_drop_cnt", 64'(drop_cnt), 64'd2);
    #2;
    pos_arst = 1'b1;
    #1;
    check("t6_arst_ev_valid",  64'(ev_valid),  64'd0);
    check("t6_arst_drop_cnt",  64'(drop_cnt),  64'd0);
    check("t6_arst_overflow",  64'(overflow),  64'd0);
    check("t6_arst_taint_cnt", 64'(taint_cnt), 64'd0);
    exp_q.delete();
    pos_arst = 1'b0;
    en = 1'b0;
    step(3);
    check("t6_post_ev_valid", 64'(ev_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
